// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the fixed-frame UART command protocol.
// The coprocessor-side decoder uses the same frame geometry, state encodings and command codes.
package uart_cmd_pkg;

  localparam int FRAME_BYTES = 18;
  localparam int DBITS       = 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEND    = 3'd1;
  localparam logic [2:0] WAIT_TX = 3'd2;
  localparam logic [2:0] RECV    = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [7:0] CMD_TEST = 8'h41;

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte receive watchdog: loadable down-counter.
// expired flags the terminal-count cycle while counting is enabled.
module uart_rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_033_400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Expires after exactly TIMEOUT_CYCLES enabled cycles since the last load.
  assign expired = en && (cnt == CW'(1));

endmodule

// File: rtl/uart_cmd_initiator.sv
// Host-side command master: serialises one request frame into the byte TX core,
// then gathers the response frame from the byte RX core, with an inter-byte timeout.
//
//   state   | meaning
//   IDLE    | ready for a new request frame
//   SEND    | pulse tx_start with byte[idx] once the TX core is free
//   WAIT_TX | wait for the TX core to finish byte[idx]
//   RECV    | collect response bytes, watchdog running
//   DONE    | hold the response until the consumer accepts it
module uart_cmd_initiator #(
  parameter int          FRAME_BYTES    = uart_cmd_pkg::FRAME_BYTES,
  parameter int          DBITS          = uart_cmd_pkg::DBITS,
  parameter int unsigned TIMEOUT_CYCLES = 1_033_400
) (
  input  logic                         clk_100MHz,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [FRAME_BYTES*DBITS-1:0] req_frame,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [FRAME_BYTES*DBITS-1:0] rsp_frame,
  output logic                         rsp_timeout,
  output logic                         tx_start,
  output logic [DBITS-1:0]             tx_data,
  input  logic                         tx_busy,
  input  logic                         rx_valid,
  input  logic [DBITS-1:0]             rx_data,
  output logic                         busy
);

  import uart_cmd_pkg::*;

  localparam int FW = FRAME_BYTES * DBITS;
  localparam int IW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [FW-1:0] req_buf;
  logic          first_wait;
  logic          last_tx_done;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_expired;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    last_tx_done = (state == WAIT_TX) && !first_wait && !tx_busy && (idx == LAST_IDX);
    tmr_load     = last_tx_done || ((state == RECV) && rx_valid);
    tmr_en       = (state == RECV);
  end

  uart_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout (
    .clk     (clk_100MHz),
    .rst_n   (reset_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      idx         <= '0;
      req_buf     <= '0;
      first_wait  <= 1'b0;
      rsp_frame   <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_buf <= req_frame;
            idx     <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            tx_data    <= req_buf[idx*DBITS +: DBITS];
            first_wait <= 1'b1;
            state      <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // tx_busy only rises the cycle after tx_start, so the first cycle here is blind.
          if (first_wait) begin
            first_wait <= 1'b0;
          end else if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              rsp_frame <= '0;
              idx       <= '0;
              state     <= RECV;
            end else begin
              idx   <= idx + IW'(1);
              state <= SEND;
            end
          end
        end
        RECV: begin
          // A byte arriving on the terminal-count cycle takes priority over the timeout.
          if (rx_valid) begin
            rsp_frame[idx*DBITS +: DBITS] <= rx_data;
            if (idx == LAST_IDX) begin
              idx         <= '0;
              rsp_valid   <= 1'b1;
              rsp_timeout <= 1'b0;
              state       <= DONE;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (tmr_expired) begin
            idx         <= '0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Self-checking bench for uart_cmd_initiator with byte-level TX/RX core models
// and a response scoreboard.
module tb_uart_cmd_initiator;

  localparam int FB = uart_cmd_pkg::FRAME_BYTES;
  localparam int DB = uart_cmd_pkg::DBITS;
  localparam int FW = FB * DB;
  localparam int TO = 100;

  typedef struct {
    logic [FW-1:0] frame;
    logic          timeout;
  } rsp_t;

  logic          clk_100MHz = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [FW-1:0] req_frame;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [FW-1:0] rsp_frame;
  logic          rsp_timeout;
  logic          tx_start;
  logic [DB-1:0] tx_data;
  logic          tx_busy;
  logic          rx_valid;
  logic [DB-1:0] rx_data;
  logic          busy;

  logic busy_model = 1'b0;
  logic busy_hold  = 1'b0;
  logic prev_busy  = 1'b0;
  int   cyc        = 0;

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] exp_tx[$];
  rsp_t          exp_rsp[$];

  assign tx_busy = busy_model | busy_hold;

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;
  always @(negedge clk_100MHz) prev_busy <= tx_busy;

  uart_cmd_initiator #(
    .FRAME_BYTES    (FB),
    .DBITS          (DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_frame   (req_frame),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_frame   (rsp_frame),
    .rsp_timeout (rsp_timeout),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte TX core model: busy for 10 cycles starting the cycle after tx_start.
  initial begin
    forever begin
      @(negedge clk_100MHz);
      if (tx_start) begin
        check("tx_busy_at_start", FW'(prev_busy), FW'(0));
        if (exp_tx.size() == 0) check("tx_extra_byte", FW'(tx_start), FW'(0));
        else check("tx_data", FW'(tx_data), FW'(exp_tx.pop_front()));
        @(posedge clk_100MHz);
        #1 busy_model = 1'b1;
        repeat (10) @(posedge clk_100MHz);
        #1 busy_model = 1'b0;
      end
    end
  end

  // Response scoreboard: compare on every rising edge of rsp_valid.
  initial begin
    logic seen;
    rsp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      if (rsp_valid && !seen) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_extra", FW'(rsp_valid), FW'(0));
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_frame", rsp_frame, e.frame);
          check("rsp_timeout", FW'(rsp_timeout), FW'(e.timeout));
        end
      end
      seen = rsp_valid;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench watchdog expired");
  end

  task automatic send_req(input logic [FW-1:0] f);
    check("req_ready_idle", FW'(req_ready), FW'(1));
    for (int i = 0; i < FB; i++) exp_tx.push_back(f[i*DB +: DB]);
    req_frame = f;
    req_valid = 1'b1;
    @(posedge clk_100MHz);
    #1 req_valid = 1'b0;
  endtask

  // Returns at posedge+1 of the edge on which the DUT enters RECV.
  task automatic wait_tx_done();
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < 3000) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("tx_all_sent", FW'(exp_tx.size()), FW'(0));
    repeat (3) @(negedge clk_100MHz);
    n = 0;
    while (tx_busy && n < 200) begin
      @(negedge clk_100MHz);
      n++;
    end
    @(posedge clk_100MHz);
    #1;
  endtask

  // The byte is sampled exactly gap clock edges after the previous call's sampling edge.
  task automatic rx_byte(input logic [DB-1:0] b, input int gap);
    repeat (gap - 1) @(posedge clk_100MHz);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk_100MHz);
    #1 rx_valid = 1'b0;
  endtask

  // Returns at the negedge where rsp_valid is seen high.
  task automatic wait_rsp(output int t);
    int n;
    n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("rsp_arrived", FW'(rsp_valid), FW'(1));
    t = cyc;
  endtask

  initial begin
    logic [FW-1:0] f;
    logic [FW-1:0] r;
    logic [DB-1:0] b;
    rsp_t          e;
    int            t0, t1, d, n;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_frame = '0;
    rsp_ready = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = '0;
    repeat (3) @(posedge clk_100MHz);
    #1 reset_n = 1'b1;
    @(posedge clk_100MHz);
    #1;

    // 1: asynchronous reset while a tx_start pulse is on the wire
    for (int i = 0; i < FB; i++) f[i*DB +: DB] = DB'(8'hA0 + i);
    send_req(f);
    n = 0;
    while (!(tx_start && exp_tx.size() <= 16) && n < 500) begin
      @(negedge clk_100MHz);
      n++;
    end
    check("rst_window_tx_start", FW'(tx_start), FW'(1));
    #1 reset_n = 1'b0;
    #1;
    check("rst_req_ready", FW'(req_ready), FW'(1));
    check("rst_busy", FW'(busy), FW'(0));
    check("rst_tx_start", FW'(tx_start), FW'(0));
    check("rst_rsp_valid", FW'(rsp_valid), FW'(0));
    check("rst_rsp_timeout", FW'(rsp_timeout), FW'(0));
    check("rst_tx_data", FW'(tx_data), FW'(0));
    check("rst_rsp_frame", rsp_frame, FW'(0));
    exp_tx.delete();
    repeat (2) @(posedge clk_100MHz);
    #1 reset_n = 1'b1;
    repeat (15) @(posedge clk_100MHz);
    #1;

    // 2: CMD_TEST request, full 18-byte response
    f = '0;
    f[DB-1:0] = uart_cmd_pkg::CMD_TEST;
    send_req(f);
    @(posedge clk_100MHz);
    #1 check("first_tx_latency", FW'(tx_start), FW'(1));
    check("first_tx_data", FW'(tx_data), FW'(8'h41));
    @(posedge clk_100MHz);
    #1 check("tx_start_one_cycle", FW'(tx_start), FW'(0));
    wait_tx_done();
    r = '0;
    for (int i = 0; i < FB; i++) begin
      if (i < 8) b = DB'(8'h31 + i);
      else if (i == 8) b = 8'h39;
      else if (i == 9) b = 8'h30;
      else b = DB'(8'h31 + (i - 10));
      r[i*DB +: DB] = b;
    end
    e.frame = r;
    e.timeout = 1'b0;
    exp_rsp.push_back(e);
    for (int i = 0; i < FB; i++) rx_byte(r[i*DB +: DB], 3);
    wait_rsp(t1);
    check("t2_first_byte", FW'(rsp_frame[7:0]), FW'(8'h31));
    check("t2_last_byte", FW'(rsp_frame[FW-1 -: DB]), FW'(8'h38));
    check("t2_no_timeout", FW'(rsp_timeout), FW'(0));
    @(posedge clk_100MHz);
    #1;

    // 3: responder goes silent after 5 bytes; stray byte during TX is dropped
    for (int i = 0; i < FB; i++) f[i*DB +: DB] = DB'($urandom_range(0, 255));
    send_req(f);
    rx_byte(8'hEE, 5);
    wait_tx_done();
    r = '0;
    for (int i = 0; i < 5; i++) r[i*DB +: DB] = DB'(8'h61 + i);
    e.frame = r;
    e.timeout = 1'b1;
    exp_rsp.push_back(e);
    for (int i = 0; i < 5; i++) rx_byte(r[i*DB +: DB], 2);
    t0 = cyc;
    wait_rsp(t1);
    d = t1 - t0;
    check("timeout_latency", FW'(d), FW'((d == TO + 1) ? TO + 1 : TO));
    check("t3_timeout_flag", FW'(rsp_timeout), FW'(1));
    check("t3_rx_bytes", FW'(rsp_frame[39:0]), FW'(r[39:0]));
    check("t3_rest_zero", FW'(rsp_frame[FW-1:40]), FW'(0));
    @(posedge clk_100MHz);
    #1;

    // 4: TX core held busy for 50 cycles before byte 3
    for (int i = 0; i < FB; i++) f[i*DB +: DB] = DB'($urandom_range(0, 255));
    send_req(f);
    n = 0;
    while (exp_tx.size() > FB - 3 && n < 500) begin
      @(negedge clk_100MHz);
      n++;
    end
    @(posedge clk_100MHz);
    #1 busy_hold = 1'b1;
    repeat (50) @(posedge clk_100MHz);
    #1;
    check("no_tx_during_hold", FW'(exp_tx.size()), FW'(FB - 3));
    busy_hold = 1'b0;
    wait_tx_done();
    for (int i = 0; i < FB; i++) r[i*DB +: DB] = DB'($urandom_range(0, 255));
    e.frame = r;
    e.timeout = 1'b0;
    exp_rsp.push_back(e);
    for (int i = 0; i < FB; i++) rx_byte(r[i*DB +: DB], 1 + (i % 4));
    wait_rsp(t1);
    @(posedge clk_100MHz);
    #1;

    // 5: response held in DONE with stray rx_valid/req_valid
    for (int i = 0; i < FB; i++) f[i*DB +: DB] = DB'($urandom_range(0, 255));
    send_req(f);
    wait_tx_done();
    rsp_ready = 1'b0;
    for (int i = 0; i < FB; i++) r[i*DB +: DB] = DB'(8'hC0 + i);
    e.frame = r;
    e.timeout = 1'b0;
    exp_rsp.push_back(e);
    for (int i = 0; i < FB; i++) rx_byte(r[i*DB +: DB], 2);
    wait_rsp(t1);
    @(posedge clk_100MHz);
    #1;
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'h55;
      end
      if (i % 10 == 5) begin
        req_valid = 1'b1;
        req_frame = ~f;
      end
      @(posedge clk_100MHz);
      #1;
      rx_valid  = 1'b0;
      req_valid = 1'b0;
      if (i % 10 == 9) begin
        check("done_frame_stable", rsp_frame, r);
        check("done_req_ready", FW'(req_ready), FW'(0));
        check("done_rsp_valid", FW'(rsp_valid), FW'(1));
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk_100MHz);
    #1;
    check("accept_req_ready", FW'(req_ready), FW'(1));
    check("accept_rsp_valid", FW'(rsp_valid), FW'(0));
    check("accept_busy", FW'(busy), FW'(0));

    // 6: reset after 7 response bytes, then a fresh transaction with terminal-cycle bytes
    for (int i = 0; i < FB; i++) f[i*DB +: DB] = DB'(8'h10 + i);
    send_req(f);
    wait_tx_done();
    for (int i = 0; i < 7; i++) rx_byte(DB'(8'hE0 + i), 2);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk_100MHz);
    #1 reset_n = 1'b1;
    check("t6_rsp_cleared", rsp_frame, FW'(0));
    check("t6_idle", FW'(busy), FW'(0));
    @(posedge clk_100MHz);
    #1;
    for (int i = 0; i < FB; i++) f[i*DB +: DB] = DB'(8'h80 + 3 * i);
    send_req(f);
    wait_tx_done();
    for (int i = 0; i < FB; i++) r[i*DB +: DB] = DB'(8'h20 + i);
    e.frame = r;
    e.timeout = 1'b0;
    exp_rsp.push_back(e);
    for (int i = 0; i < FB; i++) rx_byte(r[i*DB +: DB], (i == 0 || i == 9) ? TO : 2);
    wait_rsp(t1);
    check("t6_terminal_no_timeout", FW'(rsp_timeout), FW'(0));
    @(posedge clk_100MHz);
    #1;

    repeat (20) @(posedge clk_100MHz);
    check("tx_queue_drained", FW'(exp_tx.size()), FW'(0));
    check("rsp_queue_drained", FW'(exp_rsp.size()), FW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
